handshake_stream_gen: RTL and testbench

- Valid/ready stream transmitter: the producing end of the up_valid/up_data/up_ready interface used by the team's handshake buffers.
- Accepts one burst command (base, step, length) and emits an arithmetic data sequence beat by beat.
- Honours downstream backpressure exactly; flags the last beat; pulses done on completion.
- Used as a traffic source in front of buffer stages and as a bring-up stimulus block.

---
 rtl/handshake_stream_gen_pkg.sv | 15 +
 rtl/stream_gen_datapath.sv | 37 +++
 rtl/handshake_stream_gen.sv | 121 ++++++++++++
 tb/tb_handshake_stream_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_stream_gen_pkg.sv
// Shared state encoding and default widths for the handshake_stream_gen transmitter.
package handshake_stream_gen_pkg;

    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 16;
    localparam int DEF_GAP_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/stream_gen_datapath.sv
// Burst datapath: current data word, captured step and remaining-beat counter.
module stream_gen_datapath
    import handshake_stream_gen_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [WORD_WIDTH-1:0] base,
    input  logic [WORD_WIDTH-1:0] step,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic [WORD_WIDTH-1:0] data,
    output logic [LEN_WIDTH-1:0]  beats_left
);

    logic [WORD_WIDTH-1:0] step_q;

    // Load wins over advance; neither asserted means hold (covers backpressure stalls).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            step_q     <= '0;
            beats_left <= '0;
        end else if (load) begin
            data       <= base;
            step_q     <= step;
            beats_left <= len;
        end else if (advance) begin
            data       <= data + step_q;
            beats_left <= beats_left - LEN_WIDTH'(1);
        end
    end

endmodule

// File: rtl/handshake_stream_gen.sv
// Valid/ready burst transmitter emitting base, base+step, ... for cmd_len beats.
// Optional inter-beat idle gaps are compiled in with STREAM_GEN_GAP_EN.
module handshake_stream_gen
    import handshake_stream_gen_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [WORD_WIDTH-1:0] cmd_base,
    input  logic [WORD_WIDTH-1:0] cmd_step,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  down_valid,
    output logic [WORD_WIDTH-1:0] down_data,
    output logic                  down_last,
    input  logic                  down_ready,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  beats_left
);

`ifdef STREAM_GEN_GAP_EN
    localparam bit GAP_BUILD = 1'b1;
`else
    localparam bit GAP_BUILD = 1'b0;
`endif
    localparam bit GAP_ON = GAP_BUILD && (GAP_CYCLES > 0);

    state_t state_q, state_d;
    logic   load, advance, last_beat;

    assign last_beat = (beats_left == LEN_WIDTH'(1));

    stream_gen_datapath #(
        .WORD_WIDTH (WORD_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .advance    (advance),
        .base       (cmd_base),
        .step       (cmd_step),
        .len        (cmd_len),
        .data       (down_data),
        .beats_left (beats_left)
    );

`ifdef STREAM_GEN_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GAP_W-1:0] gap_cnt;

    // Reloaded every SEND cycle so the count is fresh when GAP is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (state_q == ST_SEND) begin
            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
        end else if (state_q == ST_GAP) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        load    = 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SEND: begin
                if (down_ready) begin
                    advance = 1'b1;
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end else if (GAP_ON) begin
                        state_d = ST_GAP;
                    end
                end
            end
`ifdef STREAM_GEN_GAP_EN
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_d = ST_SEND;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decode the state register only, never down_ready.
    assign cmd_ready  = (state_q == ST_IDLE);
    assign down_valid = (state_q == ST_SEND);
    assign down_last  = (state_q == ST_SEND) && last_beat;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_handshake_stream_gen.sv
// Bench for handshake_stream_gen: directed and random bursts against a beat-index reference model.
module tb_handshake_stream_gen;

    localparam int WW      = 32;
    localparam int LW      = 16;
    localparam int GAP_CYC = 2;
`ifdef STREAM_GEN_GAP_EN
    localparam int GAP_AFTER = GAP_CYC;
`else
    localparam int GAP_AFTER = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [WW-1:0] cmd_base;
    logic [WW-1:0] cmd_step;
    logic [LW-1:0] cmd_len;
    logic          down_valid;
    logic [WW-1:0] down_data;
    logic          down_last;
    logic          down_ready;
    logic          busy;
    logic          done;
    logic [LW-1:0] beats_left;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    handshake_stream_gen #(
        .WORD_WIDTH (WW),
        .LEN_WIDTH  (LW),
        .GAP_CYCLES (GAP_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_base   (cmd_base),
        .cmd_step   (cmd_step),
        .cmd_len    (cmd_len),
        .down_valid (down_valid),
        .down_data  (down_data),
        .down_last  (down_last),
        .down_ready (down_ready),
        .busy       (busy),
        .done       (done),
        .beats_left (beats_left)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 1);
        chk({tag, "_valid"},     64'(down_valid), 0);
        chk({tag, "_data"},      64'(down_data), 0);
        chk({tag, "_last"},      64'(down_last), 0);
        chk({tag, "_busy"},      64'(busy), 0);
        chk({tag, "_done"},      64'(done), 0);
        chk({tag, "_left"},      64'(beats_left), 0);
    endtask

    // Called at a falling edge while the DUT is idle; returns one falling edge later.
    task automatic issue(input logic [WW-1:0] b, input logic [WW-1:0] s,
                         input logic [LW-1:0] l, input bit keep);
        cmd_base  = b;
        cmd_step  = s;
        cmd_len   = l;
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", 64'(cmd_ready), 1);
        @(negedge clk);
        if (!keep) begin
            cmd_valid = 1'b0;
            cmd_base  = $urandom;
            cmd_step  = $urandom;
            cmd_len   = LW'($urandom);
        end
    endtask

    // Reference model: beat k carries b + k*s; the beat index only moves on valid & ready.
    task automatic play(input logic [WW-1:0] b, input logic [WW-1:0] s,
                        input logic [LW-1:0] l, input int mode);
        logic [WW-1:0] exp_data;
        int  n;
        int  i;
        int  cyc;
        int  gap_rem;
        bit  r;
        bit  pat [7];
        pat     = '{1, 0, 0, 1, 0, 1, 1};
        n       = int'(l);
        i       = 0;
        cyc     = 0;
        gap_rem = 0;
        if (n == 0) begin
            chk("zl_valid",     64'(down_valid), 0);
            chk("zl_done",      64'(done), 1);
            chk("zl_busy",      64'(busy), 1);
            chk("zl_cmd_ready", 64'(cmd_ready), 0);
        end else begin
            while (i < n) begin
                if (cyc >= 2000) begin
                    chk("beat_timeout", 64'(i), 64'(n));
                    break;
                end
                if (gap_rem > 0) begin
                    chk("gap_valid",     64'(down_valid), 0);
                    chk("gap_cmd_ready", 64'(cmd_ready), 0);
                    chk("gap_left",      64'(beats_left), 64'(n - i));
                    gap_rem--;
                    down_ready = 1'($urandom_range(0, 1));
                end else begin
                    exp_data = b + WW'(i) * s;
                    chk("valid",          64'(down_valid), 1);
                    chk("data",           64'(down_data), 64'(exp_data));
                    chk("last",           64'(down_last), 64'(i == n - 1));
                    chk("beats_left",     64'(beats_left), 64'(n - i));
                    chk("cmd_ready_busy", 64'(cmd_ready), 0);
                    chk("busy",           64'(busy), 1);
                    chk("done_mid",       64'(done), 0);
                    case (mode)
                        0:       r = 1'b1;
                        1:       r = 1'($urandom_range(0, 1));
                        default: r = (cyc < 7) ? pat[cyc] : 1'b1;
                    endcase
                    down_ready = r;
                    if (r) begin
                        i++;
                        if (i < n) gap_rem = GAP_AFTER;
                    end
                end
                cyc++;
                @(negedge clk);
            end
            chk("end_valid",     64'(down_valid), 0);
            chk("done_pulse",    64'(done), 1);
            chk("end_left",      64'(beats_left), 0);
            chk("end_cmd_ready", 64'(cmd_ready), 0);
        end
        down_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("done_drop",  64'(done), 0);
        chk("idle_ready", 64'(cmd_ready), 1);
        chk("idle_busy",  64'(busy), 0);
        chk("idle_valid", 64'(down_valid), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [WW-1:0] rb;
        logic [WW-1:0] rs;
        logic [LW-1:0] rl;

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_base   = '0;
        cmd_step   = '0;
        cmd_len    = '0;
        down_ready = 1'b0;
        #12;
        chk_reset_vals("por");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_release_ready", 64'(cmd_ready), 1);

        issue(32'h10, 32'd4, 16'd3, 1'b0);
        play(32'h10, 32'd4, 16'd3, 0);

        issue(32'd5, 32'd1, 16'd4, 1'b0);
        play(32'd5, 32'd1, 16'd4, 2);

        issue(32'hFFFF_FFFE, 32'd1, 16'd3, 1'b0);
        play(32'hFFFF_FFFE, 32'd1, 16'd3, 0);

        issue(32'd123, 32'd7, 16'd0, 1'b0);
        play(32'd123, 32'd7, 16'd0, 0);

        // cmd_valid stays high with the next command on the bus during the first burst.
        issue(32'h100, 32'd2, 16'd2, 1'b1);
        cmd_base = 32'h200;
        cmd_step = 32'd3;
        cmd_len  = 16'd2;
        play(32'h100, 32'd2, 16'd2, 0);
        issue(32'h200, 32'd3, 16'd2, 1'b0);
        play(32'h200, 32'd3, 16'd2, 1);

        for (int k = 0; k < 6; k++) begin
            rb = $urandom;
            rs = $urandom;
            rl = LW'($urandom_range(1, 12));
            issue(rb, rs, rl, 1'b0);
            play(rb, rs, rl, 1);
        end

        // Asynchronous reset in the middle of a burst.
        issue(32'h40, 32'd8, 16'd10, 1'b0);
        down_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_done",  64'(done), 0);
            chk("rst_no_valid", 64'(down_valid), 0);
        end

        issue(32'd7, 32'd3, 16'd2, 1'b0);
        play(32'd7, 32'd3, 16'd2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
